// File: rtl/module_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Accepts a WIDTH-bit unsigned value on start, clamps it to MAX_VAL and
// emits four registered BCD digits with a one-cycle listo pulse.
module module_bin_bcd #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] valor,
  input  logic             start,
  output logic [3:0]       unidades_input,
  output logic [3:0]       decenas_input,
  output logic [3:0]       centenas_input,
  output logic [3:0]       millares_input,
  output logic             listo,
  output logic             busy,
  output logic             sat
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_bcd;
  logic [WIDTH-1:0] r_bin;
  logic             r_ovf;

  logic             w_ovf;
  logic [WIDTH-1:0] w_load;
  logic [15:0]      w_adj;
  logic [WIDTH+15:0] w_sr;

  // Clamp the incoming value; comparison is done at 32 bits so MAX_VAL
  // may exceed the representable range of narrow WIDTH settings.
  always_comb begin
    w_ovf  = (32'(valor) > MAX_VAL);
    w_load = w_ovf ? WIDTH'(MAX_VAL) : valor;
  end

  // Add-3 correction on every nibble >= 5, then shift {bcd,bin} left by one.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
    w_sr = {w_adj, r_bin} << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: last shift happens when the counter is at 1.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Conversion datapath: load on accepted start, shift while in SHIFT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bcd <= '0;
            r_bin <= w_load;
            r_cnt <= CW'(WIDTH);
            r_ovf <= w_ovf;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_sr[WIDTH+15:WIDTH];
          r_bin <= w_sr[WIDTH-1:0];
          r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output registers: digits and sat only change in DONE, listo pulses once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unidades_input <= '0;
      decenas_input  <= '0;
      centenas_input <= '0;
      millares_input <= '0;
      sat            <= 1'b0;
      listo          <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (r_state == S_DONE) begin
        unidades_input <= r_bcd[3:0];
        decenas_input  <= r_bcd[7:4];
        centenas_input <= r_bcd[11:8];
        millares_input <= r_bcd[15:12];
        sat            <= r_ovf;
        listo          <= 1'b1;
      end
    end
  end

  // Busy covers SHIFT and DONE.
  always_comb begin
    busy = (r_state != S_IDLE);
  end

endmodule
